// File: rtl/btn_step_counter.sv
// btn_step_counter: two debounced push-buttons with hold-to-auto-repeat driving a wrapping up/down count.
// Ports:
//   clk      - board clock, the only clock
//   rst      - synchronous active-high reset
//   btn_up   - raw asynchronous up button, active-high
//   btn_dn   - raw asynchronous down button, active-high
//   count    - current WIDTH-bit count
//   up_pulse - one-cycle strobe for every up step (press or repeat)
//   dn_pulse - one-cycle strobe for every down step (press or repeat)
module btn_step_counter #(
    parameter int WIDTH           = 4,
    parameter int RESET_VALUE     = 0,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int HOLD_CYCLES     = 62500000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             dn_pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

    logic [1:0] btn;
    logic [1:0] step;

    assign btn = {btn_dn, btn_up};

    // Index 0 is the up button, index 1 the down button.
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          sync1_q, sync2_q;
        logic          stable_q, stable_d;
        logic [DW-1:0] db_q, db_d;
        logic [TW-1:0] tmr_q, tmr_d;
        state_e        state_q, state_d;
        logic          step_c;

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                stable_q <= 1'b0;
                db_q     <= '0;
                tmr_q    <= '0;
                state_q  <= IDLE;
            end else begin
                sync1_q  <= btn[g];
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                db_q     <= db_d;
                tmr_q    <= tmr_d;
                state_q  <= state_d;
            end
        end

        always_comb begin
            db_d     = (sync2_q == stable_q || db_q == DB_LAST) ? '0 : db_q + 1'b1;
            stable_d = (sync2_q != stable_q && db_q == DB_LAST) ? sync2_q : stable_q;
            state_d  = state_q;
            tmr_d    = tmr_q;
            step_c   = 1'b0;
            // IDLE is only re-entered once stable has dropped, so stable high here is a fresh press.
            if (state_q == IDLE) begin
                if (stable_q) begin
                    step_c  = 1'b1;
                    state_d = HOLD;
                    tmr_d   = '0;
                end
            end else if (!stable_q) begin
                // A release beats any step due on the same edge.
                state_d = IDLE;
                tmr_d   = '0;
            end else if (state_q == HOLD && tmr_q == HOLD_LAST) begin
                step_c  = 1'b1;
                state_d = REPEAT;
                tmr_d   = '0;
            end else if (state_q == REPEAT && tmr_q == REP_LAST) begin
                step_c = 1'b1;
                tmr_d  = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        assign step[g] = step_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= WIDTH'(RESET_VALUE);
            up_pulse <= 1'b0;
            dn_pulse <= 1'b0;
        end else begin
            count    <= (step == 2'b01) ? count + 1'b1 :
                        (step == 2'b10) ? count - 1'b1 : count;
            up_pulse <= step[0];
            dn_pulse <= step[1];
        end
    end
endmodule

// File: tb/tb_btn_step_counter.sv
// tb_btn_step_counter: scoreboard bench for btn_step_counter with short debounce/hold/repeat timings.
module tb_btn_step_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [3:0] count;
    logic       up_pulse;
    logic       dn_pulse;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int t0 = 0;

    typedef struct {
        int         e;
        logic       u;
        logic       d;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    exp_t got;

    btn_step_counter #(
        .WIDTH(4),
        .RESET_VALUE(0),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .count(count),
        .up_pulse(up_pulse),
        .dn_pulse(dn_pulse)
    );

    always #4 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected pulse off edges after the edge at which the buttons were last driven (t0).
    task automatic expect_step(input int off, input logic u, input logic d, input logic [3:0] c);
        exp_t x;
        x.e = t0 + off;
        x.u = u;
        x.d = d;
        x.c = c;
        q.push_back(x);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Single press of 8 samples: press step only, released long before the first repeat.
    task automatic tap(input logic u, input logic d, input logic [3:0] c);
        t0 = edge_n;
        btn_up = u;
        btn_dn = d;
        expect_step(7, u, d, c);
        wait_edges(8);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        wait_edges(20);
        check_val("tap_count", int'(count), int'(c));
    endtask

    always @(negedge clk) begin
        if (up_pulse || dn_pulse) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: edge %0d up %0b dn %0b count %0d, want no pulse",
                         edge_n, up_pulse, dn_pulse, count);
            end else begin
                got = q.pop_front();
                if (got.e != edge_n || got.u != up_pulse || got.d != dn_pulse || got.c != count) begin
                    errors++;
                    $display("FAIL step: edge %0d up %0b dn %0b count %0d, want edge %0d up %0b dn %0b count %0d",
                             edge_n, up_pulse, dn_pulse, count, got.e, got.u, got.d, got.c);
                end
            end
        end
    end

    initial begin
        wait_edges(3);
        check_val("reset_count", int'(count), 0);
        check_val("reset_up", int'(up_pulse), 0);
        check_val("reset_dn", int'(dn_pulse), 0);
        rst = 1'b0;

        // Debounce latency: sampled high at t0+1, press pulse after edge t0+7.
        t0 = edge_n;
        btn_up = 1'b1;
        expect_step(7, 1'b1, 1'b0, 4'd1);
        wait_edges(8);
        btn_up = 1'b0;
        wait_edges(20);
        check_val("latency_count", int'(count), 1);

        // Glitches of 3 and 2 samples never reach DEBOUNCE_CYCLES.
        btn_dn = 1'b1;
        wait_edges(3);
        btn_dn = 1'b0;
        wait_edges(3);
        btn_dn = 1'b1;
        wait_edges(2);
        btn_dn = 1'b0;
        wait_edges(15);
        check_val("glitch_count", int'(count), 1);

        // Auto-repeat: press, +10, then every 5; release lands on the edge a repeat was due.
        t0 = edge_n;
        btn_up = 1'b1;
        expect_step(7, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 5; i++) expect_step(17 + 5 * i, 1'b1, 1'b0, 4'(3 + i));
        wait_edges(35);
        btn_up = 1'b0;
        wait_edges(20);
        check_val("repeat_count", int'(count), 7);

        // Simultaneous press: paired pulses, count frozen.
        t0 = edge_n;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        expect_step(7, 1'b1, 1'b1, 4'd7);
        expect_step(17, 1'b1, 1'b1, 4'd7);
        expect_step(22, 1'b1, 1'b1, 4'd7);
        expect_step(27, 1'b1, 1'b1, 4'd7);
        wait_edges(25);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        wait_edges(20);
        check_val("both_count", int'(count), 7);

        // Reset while in REPEAT with the button still held.
        t0 = edge_n;
        btn_up = 1'b1;
        expect_step(7, 1'b1, 1'b0, 4'd8);
        expect_step(17, 1'b1, 1'b0, 4'd9);
        wait_edges(19);
        rst = 1'b1;
        wait_edges(1);
        check_val("midrst_count", int'(count), 0);
        check_val("midrst_up", int'(up_pulse), 0);
        rst = 1'b0;
        expect_step(27, 1'b1, 1'b0, 4'd1);
        wait_edges(10);
        btn_up = 1'b0;
        wait_edges(20);
        check_val("after_rst_count", int'(count), 1);

        // Wrap in both directions.
        tap(1'b0, 1'b1, 4'd0);
        tap(1'b0, 1'b1, 4'd15);
        tap(1'b1, 1'b0, 4'd0);

        wait_edges(5);
        check_val("pending_steps", q.size(), 0);
        check_val("final_count", int'(count), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
